// File: rtl/noc_pkg.sv
// Shared NOC definitions: output-port codes, requester FSM states and the
// XY dimension-order routing function used by every input-port requester.
package noc_pkg;

    localparam logic [2:0] PORT_N    = 3'd0;
    localparam logic [2:0] PORT_S    = 3'd1;
    localparam logic [2:0] PORT_W    = 3'd2;
    localparam logic [2:0] PORT_E    = 3'd3;
    localparam logic [2:0] PORT_L    = 3'd4;
    // Matches no output arbiter comparator, so it never wins a grant.
    localparam logic [2:0] PORT_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } req_state_t;

    // X is resolved first, then Y; coordinates are zero-extended and compared unsigned.
    function automatic logic [2:0] xy_route(input logic [7:0] dest_x,
                                            input logic [7:0] dest_y,
                                            input logic [7:0] own_x,
                                            input logic [7:0] own_y);
        logic [2:0] port;
        if (dest_x > own_x)      port = PORT_E;
        else if (dest_x < own_x) port = PORT_W;
        else if (dest_y > own_y) port = PORT_S;
        else if (dest_y < own_y) port = PORT_N;
        else                     port = PORT_L;
        return port;
    endfunction

endpackage

// File: rtl/input_port_requester_flit_fifo.sv
// flit_fifo: circular input buffer for single-flit packets. Besides the head
// it exposes the flit behind the head and the occupancy, so the requester can
// route the next packet in the same cycle it pops the current one.
module flit_fifo #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [FLIT_W-1:0]          din,
    output logic [FLIT_W-1:0]          dout,
    output logic [FLIT_W-1:0]          dout_nxt,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    // Overflow/underflow requests are dropped here so callers cannot corrupt state.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign dout     = mem_q[rd_ptr_q];
    assign dout_nxt = mem_q[rd_ptr_q + AW'(1)];

    // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array; contents are don't-care until written, so it is not reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/input_port_requester.sv
// input_port_requester: buffers flits from one router input, requests the
// XY-routed output port from the round-robin arbiters, and forwards the head
// flit to the crossbar for one cycle once granted.
// Optional: define REQ_TIMEOUT_EN to build the starvation wait counter that
// drives starve_o; otherwise starve_o is tied low.
module input_port_requester
    import noc_pkg::*;
#(
    parameter int FLIT_W  = 16,
    parameter int COORD_W = 2,
    parameter int DEPTH   = 4,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [FLIT_W-1:0] in_flit_i,
    output logic              in_ready_o,
    output logic [2:0]        nexthop_addr_o,
    input  logic [4:0]        grant_i,
    output logic              out_valid_o,
    output logic [FLIT_W-1:0] out_flit_o,
    output logic              change_order_o,
    output logic              starve_o
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    req_state_t        state_q;
    logic [2:0]        route_q;
    logic              out_valid_q, change_order_q;
    logic [FLIT_W-1:0] out_flit_q;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FLIT_W-1:0] head, head_nxt, nxt_flit;
    logic [CNTW-1:0]   fifo_cnt;
    logic [7:0]        grant_ext;
    logic              grant_hit, more_d;
    logic [2:0]        head_route, nxt_route;

    // Ready depends only on registered occupancy; a pop this cycle does not free a slot early.
    assign in_ready_o = !fifo_full;
    assign fifo_push  = in_valid_i && !fifo_full;
    assign fifo_pop   = (state_q == SEND);

    flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .din      (in_flit_i),
        .dout     (head),
        .dout_nxt (head_nxt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // While sending, the next head is the second entry, or the flit arriving now if only one is left.
    assign nxt_flit = (fifo_cnt > CNTW'(1)) ? head_nxt : in_flit_i;
    assign more_d   = (fifo_cnt > CNTW'(1)) || fifo_push;

    assign head_route = xy_route(8'(head[FLIT_W-1 -: COORD_W]),
                                 8'(head[FLIT_W-COORD_W-1 -: COORD_W]),
                                 8'(X_COORD), 8'(Y_COORD));
    assign nxt_route  = xy_route(8'(nxt_flit[FLIT_W-1 -: COORD_W]),
                                 8'(nxt_flit[FLIT_W-COORD_W-1 -: COORD_W]),
                                 8'(X_COORD), 8'(Y_COORD));

    // Only the grant bit for the port we are requesting counts.
    assign grant_ext = {3'b000, grant_i};
    assign grant_hit = grant_ext[route_q];

    // Request/grant/send handshake with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            route_q        <= PORT_NONE;
            out_valid_q    <= 1'b0;
            out_flit_q     <= '0;
            change_order_q <= 1'b0;
        end else begin
            out_valid_q    <= 1'b0;
            out_flit_q     <= '0;
            change_order_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= REQ;
                        route_q <= head_route;
                    end
                end
                REQ: begin
                    if (grant_hit) begin
                        state_q        <= SEND;
                        out_valid_q    <= 1'b1;
                        out_flit_q     <= head;
                        change_order_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (more_d) begin
                        state_q <= REQ;
                        route_q <= nxt_route;
                    end else begin
                        state_q <= IDLE;
                        route_q <= PORT_NONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    route_q <= PORT_NONE;
                end
            endcase
        end
    end

    assign nexthop_addr_o = route_q;
    assign out_valid_o    = out_valid_q;
    assign out_flit_o     = out_flit_q;
    assign change_order_o = change_order_q;

    // Low payload bits of the look-ahead flit play no part in routing.
    logic unused_nxt_bits;
    assign unused_nxt_bits = ^nxt_flit[FLIT_W-2*COORD_W-1:0];

`ifdef REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_q;
    logic          starve_q;

    // Saturating REQ wait counter; starvation is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else if (state_q == SEND) begin
            wait_q <= '0;
        end else if (state_q == REQ && wait_q != TW'(TIMEOUT)) begin
            wait_q <= wait_q + TW'(1);
            if (wait_q == TW'(TIMEOUT - 1)) starve_q <= 1'b1;
        end
    end

    assign starve_o = starve_q;
`else
    logic unused_timeout;
    assign unused_timeout = |32'(TIMEOUT);
    assign starve_o       = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_requester.sv
// Directed + randomized bench for input_port_requester at router (1,1).
module tb_input_port_requester;

    localparam int FW = 16;
`ifdef REQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [FW-1:0] in_flit;
    logic          in_ready;
    logic [2:0]    nexthop;
    logic [4:0]    grant;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          chg;
    logic          starve;

    int errors = 0;
    int checks = 0;
    logic [FW-1:0] q[$];

    always #5 clk = ~clk;

    input_port_requester #(
        .FLIT_W(16), .COORD_W(2), .DEPTH(4),
        .X_COORD(1), .Y_COORD(1), .TIMEOUT(15)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_i     (in_valid),
        .in_flit_i      (in_flit),
        .in_ready_o     (in_ready),
        .nexthop_addr_o (nexthop),
        .grant_i        (grant),
        .out_valid_o    (out_valid),
        .out_flit_o     (out_flit),
        .change_order_o (chg),
        .starve_o       (starve)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference routing for a router at (1,1): X first, then Y, else local.
    function automatic logic [2:0] ref_route(input logic [FW-1:0] f);
        int dx, dy;
        dx = int'(f[15:14]);
        dy = int'(f[13:12]);
        if (dx > 1) return 3'd3;
        if (dx < 1) return 3'd2;
        if (dy > 1) return 3'd1;
        if (dy < 1) return 3'd0;
        return 3'd4;
    endfunction

    function automatic logic [FW-1:0] mkflit(input int dx, input int dy);
        return {2'(dx), 2'(dy), 12'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [FW-1:0] f);
        in_valid = 1'b1;
        in_flit  = f;
        tick();
        in_valid = 1'b0;
        q.push_back(f);
    endtask

    // Expects the DUT to be requesting for q[0]; grants exactly that port.
    task automatic serve(input string tag);
        logic [2:0] r;
        r = ref_route(q[0]);
        chk({tag, "_req"}, 32'(nexthop), 32'(r));
        grant = 5'(1 << r);
        tick();
        chk({tag, "_vld"}, 32'(out_valid), 1);
        chk({tag, "_chg"}, 32'(chg), 1);
        chk({tag, "_flit"}, 32'(out_flit), 32'(q[0]));
        chk({tag, "_hold"}, 32'(nexthop), 32'(r));
        grant = '0;
        void'(q.pop_front());
        tick();
        chk({tag, "_vld0"}, 32'(out_valid), 0);
        chk({tag, "_chg0"}, 32'(chg), 0);
        chk({tag, "_rdy"}, 32'(in_ready), 1);
        if (q.size() == 0) chk({tag, "_none"}, 32'(nexthop), 7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] fa, fb, extra;
        logic [4:0]    w;
        logic [2:0]    r;
        int            pulse_cyc[$];
        logic [FW-1:0] pulse_flit[$];
        logic [2:0]    pulse_hop[$];

        reset = 1'b0; in_valid = 1'b0; in_flit = '0; grant = '0;
        #12;
        chk("rst_hop", 32'(nexthop), 7);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_flit", 32'(out_flit), 0);
        chk("rst_chg", 32'(chg), 0);
        chk("rst_starve", 32'(starve), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        reset = 1'b1;

        // East-bound flit: request two cycles after the push.
        push_flit(mkflit(2, $urandom_range(0, 3)));
        chk("t1_idle", 32'(nexthop), 7);
        tick();
        serve("t1");

        // North-bound flit ignores a grant for another port.
        push_flit(mkflit(1, 0));
        tick();
        chk("t2_req", 32'(nexthop), 0);
        grant = 5'b01000;
        repeat (3) begin
            tick();
            chk("t2_novld", 32'(out_valid), 0);
            chk("t2_hold", 32'(nexthop), 0);
        end
        grant = '0;
        serve("t2");

        // Fill to full, then a refused fifth push; drain in order.
        for (int i = 0; i < 4; i++) begin
            fa = mkflit($urandom_range(0, 3), $urandom_range(0, 3));
            chk("t3_rdy", 32'(in_ready), 1);
            in_valid = 1'b1;
            in_flit  = fa;
            tick();
            q.push_back(fa);
        end
        chk("t3_full", 32'(in_ready), 0);
        extra = mkflit(3, 3);
        in_flit = extra;
        tick();
        in_valid = 1'b0;
        chk("t3_refuse", 32'(in_ready), 0);
        for (int i = 0; i < 4; i++) serve("t3");

        // Local then west, back to back with all grants asserted.
        fa = mkflit(1, 1);
        fb = mkflit(0, 1);
        grant = 5'b11111;
        in_valid = 1'b1; in_flit = fa;
        tick();
        in_flit = fb;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (chg === 1'b1) begin
                pulse_cyc.push_back(c);
                pulse_flit.push_back(out_flit);
                pulse_hop.push_back(nexthop);
            end
            tick();
        end
        grant = '0;
        chk("t4_npulse", 32'(pulse_cyc.size()), 2);
        if (pulse_cyc.size() == 2) begin
            chk("t4_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 2);
            chk("t4_flit0", 32'(pulse_flit[0]), 32'(fa));
            chk("t4_flit1", 32'(pulse_flit[1]), 32'(fb));
            chk("t4_hop0", 32'(pulse_hop[0]), 4);
            chk("t4_hop1", 32'(pulse_hop[1]), 2);
        end
        chk("t4_idle", 32'(nexthop), 7);

        // Reset while requesting with two flits buffered.
        in_valid = 1'b1; in_flit = mkflit(3, 0);
        tick();
        in_flit = mkflit(0, 3);
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t5_hop", 32'(nexthop), 7);
        chk("t5_vld", 32'(out_valid), 0);
        chk("t5_rdy", 32'(in_ready), 1);
        chk("t5_chg", 32'(chg), 0);
        #2 reset = 1'b1;
        grant = 5'b11111;
        repeat (5) begin
            tick();
            chk("t5_nostale", 32'(out_valid), 0);
            chk("t5_idle", 32'(nexthop), 7);
        end
        grant = '0;

        // Reset during SEND suppresses the change_order pulse at once.
        push_flit(mkflit(2, 2));
        tick();
        grant = 5'b11111;
        tick();
        chk("t5b_send", 32'(chg), 1);
        #2 reset = 1'b0;
        #1;
        chk("t5b_chg", 32'(chg), 0);
        chk("t5b_vld", 32'(out_valid), 0);
        chk("t5b_flit", 32'(out_flit), 0);
        #2 reset = 1'b1;
        grant = '0;
        q.delete();
        tick();
        chk("t5b_idle", 32'(nexthop), 7);

        // Randomized: wrong-port grants for a random spell, then the right one.
        for (int i = 0; i < 12; i++) begin
            push_flit(mkflit($urandom_range(0, 3), $urandom_range(0, 3)));
            tick();
            r = ref_route(q[0]);
            w = 5'($urandom);
            w[r] = 1'b0;
            grant = w;
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd_novld", 32'(out_valid), 0);
                chk("rnd_hold", 32'(nexthop), 32'(r));
            end
            grant = '0;
            serve("rnd");
        end

        // Starvation: 15 cycles in REQ without a grant.
        push_flit(mkflit(0, 0));
        tick();
        repeat (14) tick();
        chk("t7_pre", 32'(starve), 0);
        tick();
        chk("t7_set", 32'(starve), 32'(TO_EN));
        serve("t7");
        chk("t7_sticky", 32'(starve), 32'(TO_EN));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_port_requester.md
Name: input_port_requester

Overview:
- Requester side of the NOC output-port round-robin arbitration handshake: one instance per router input port (N/S/W/E/L).
- Buffers incoming single-flit packets and computes the XY-routed next-hop port of the head flit.
- Drives the 3-bit next-hop address that every per-output rr_processor compares, waits for that arbiter's grant, then forwards the flit to the crossbar and pulses change_order to advance the round-robin registers.

Parameters:
- FLIT_W, 16, flit width in bits.
- COORD_W, 2, width of each destination coordinate field.
- DEPTH, 4, input FIFO depth in flits; power of two, at least 2.
- X_COORD, 0, this router's X coordinate.
- Y_COORD, 0, this router's Y coordinate.
- TIMEOUT, 15, starvation threshold in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  upstream flit valid.
- in_flit_i  in  FLIT_W  upstream flit; dest X is bits [FLIT_W-1 -: COORD_W]; dest Y is the next COORD_W bits below it.
- in_ready_o  out  1  FIFO can accept a flit.
- nexthop_addr_o  out  3  requested output port code, routed to all output arbiters.
- grant_i  in  5  one-hot grant from the output arbiters, indexed by port code.
- out_valid_o  out  1  flit presented to the crossbar this cycle.
- out_flit_o  out  FLIT_W  flit to the crossbar.
- change_order_o  out  1  one-cycle pulse per forwarded flit; drives rr_register_change_order_i.
- starve_o  out  1  sticky starvation flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; state = IDLE.
  - nexthop_addr_o = 3'b111 (NONE), out_valid_o = 0, out_flit_o = 0, change_order_o = 0, starve_o = 0.
  - in_ready_o = 1.
- Port codes: N=0, S=1, W=2, E=3, L=4, NONE=7. NONE matches no arbiter comparator.
- FIFO:
  - Push when in_valid_i && in_ready_o; in_ready_o = !full, derived from registered state only (no same-cycle pop pass-through).
  - Pointers wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
  - Simultaneous push and pop when not full: both occur and occupancy is unchanged.
  - A push into an empty FIFO becomes visible at the head on the next cycle.
- XY routing on the head flit:
  - destX > X_COORD -> E; destX < X_COORD -> W.
  - Otherwise destY > Y_COORD -> S; destY < Y_COORD -> N.
  - Otherwise L.
  - Comparisons are unsigned.
- State machine:
  - IDLE: nexthop_addr_o = NONE. Go to REQ when the FIFO is non-empty.
  - REQ: nexthop_addr_o is the registered route of the head flit, computed at IDLE->REQ or at SEND->REQ. Hold it stable until a grant arrives.
    - grant_i[route] = 1 -> go to SEND.
    - Grant bits for other ports, or any grant in IDLE, are ignored.
  - SEND (exactly one cycle):
    - out_valid_o = 1, out_flit_o = head flit, change_order_o = 1.
    - FIFO pops.
    - Next state = REQ if a flit remains (after counting a same-cycle push), else IDLE.
    - nexthop_addr_o stays equal to the old route during SEND.
- Latency: a flit pushed into an empty FIFO at cycle t gives IDLE->REQ at t+1 and request visible at t+2. A grant in cycle g gives SEND in cycle g+1. Back-to-back flits reach SEND at most every 2 cycles.
- Reset asserted mid-REQ or mid-SEND: the flit is dropped, no change_order pulse is issued, and all outputs return to their reset values immediately.

Optional Feature:
- REQ_TIMEOUT_EN defined:
  - A wait counter (clog2(TIMEOUT+1) bits, saturating) counts cycles spent in REQ and clears on SEND.
  - When it reaches TIMEOUT, starve_o sets and stays set until reset.
- REQ_TIMEOUT_EN undefined: no counter is built; starve_o is tied to 0.

Decomposition:
- Package noc_pkg:
  - port code constants PORT_N/S/W/E/L/NONE;
  - state enum req_state_t {IDLE, REQ, SEND};
  - xy_route function (dest X, dest Y, own X, own Y -> 3-bit code).
- Sub-module: flit_fifo (parameters FLIT_W, DEPTH; ports push, pop, din, dout, full, empty).

Test Plan:
- X_COORD=1, Y_COORD=1; push flit with destX=2 at t0 -> nexthop_addr_o=3 at t0+2. Hold grant_i=5'b01000 -> next cycle out_valid_o=1, change_order_o=1, and the flit appears on out_flit_o.
- Push destX=1, destY=0 -> nexthop=0 (N). Assert grant_i=5'b01000 (wrong port) -> no SEND, nexthop stays 0.
- Push 4 flits with no grant -> in_ready_o=0 after the 4th push and a 5th push is refused. Then grant -> in_ready_o=1 the cycle after SEND, with FIFO order preserved.
- Destinations (1,1) and (0,1) back-to-back, each granted immediately -> L then W; change_order_o pulses twice, 2 cycles apart.
- Drop reset during REQ with 2 flits buffered -> nexthop=7, out_valid_o=0, in_ready_o=1 at once; after release, no stale flit is forwarded.
- REQ_TIMEOUT_EN, TIMEOUT=15: withhold grant for 15 cycles -> starve_o=1 and stays 1 after a later grant.
